// File: rtl/vx_kmu_cta_scheduler_if.sv
// Kernel-launch / per-core dispatch bundle between the command processor, the
// CTA scheduler and the cores. master = scheduler side, slave = environment.
interface vx_kmu_cta_scheduler_if #(
  parameter int NUM_TARGETS = 4,
  parameter int XLEN        = 32
);
  logic                   launch_valid;
  logic                   launch_ready;
  logic [XLEN-1:0]        launch_pc;
  logic [XLEN-1:0]        launch_param;
  logic [31:0]            launch_grid_x;
  logic [31:0]            launch_grid_y;
  logic [31:0]            launch_grid_z;
  logic [NUM_TARGETS-1:0] target_ready;
  logic                   dispatch_valid;
  logic [NUM_TARGETS-1:0] dispatch_sel;
  logic [XLEN-1:0]        dispatch_pc;
  logic [XLEN-1:0]        dispatch_param;
  logic [31:0]            dispatch_cta_x;
  logic [31:0]            dispatch_cta_y;
  logic [31:0]            dispatch_cta_z;
  logic [31:0]            dispatch_cta_id;
  logic [NUM_TARGETS-1:0] cta_done;
  logic                   kernel_done;
  logic                   busy;

  modport master (
    input  launch_valid, launch_pc, launch_param,
           launch_grid_x, launch_grid_y, launch_grid_z,
           target_ready, cta_done,
    output launch_ready, dispatch_valid, dispatch_sel, dispatch_pc, dispatch_param,
           dispatch_cta_x, dispatch_cta_y, dispatch_cta_z, dispatch_cta_id,
           kernel_done, busy
  );

  modport slave (
    output launch_valid, launch_pc, launch_param,
           launch_grid_x, launch_grid_y, launch_grid_z,
           target_ready, cta_done,
    input  launch_ready, dispatch_valid, dispatch_sel, dispatch_pc, dispatch_param,
           dispatch_cta_x, dispatch_cta_y, dispatch_cta_z, dispatch_cta_id,
           kernel_done, busy
  );
endinterface

// File: rtl/vx_kmu_cta_scheduler.sv
// Walks a 3-D grid x-fastest, issuing one CTA per cycle to a round-robin
// selected free core, then waits for all CTAs to retire before kernel_done.
module vx_kmu_cta_scheduler #(
  parameter int NUM_TARGETS = 4,
  parameter int XLEN        = 32
) (
  input logic clk,
  input logic reset,
  vx_kmu_cta_scheduler_if.master bus
);
  localparam int IW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TARGETS - 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

  state_t                 state;
  logic [XLEN-1:0]        pc;
  logic [XLEN-1:0]        param;
  logic [31:0]            grid_x, grid_y, grid_z;
  logic [31:0]            cta_x, cta_y, cta_z, cta_id;
  logic [31:0]            outstanding;
  logic [IW-1:0]          last_grant;

  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          cand_idx;
  logic                   found;
  int                     cand;
  logic [31:0]            done_cnt;
  logic [31:0]            outstanding_next;
  logic [NUM_TARGETS-1:0] sel_onehot;
  logic                   fire;
  logic                   last_cta;
  logic                   underflow;

  // Rotating priority search starting just above the previous grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      cand     = (int'(last_grant) + 1 + k) % NUM_TARGETS;
      cand_idx = IW'(cand);
      if (!found && bus.target_ready[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    done_cnt = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      done_cnt = done_cnt + 32'(bus.cta_done[k]);
    end
  end

  assign fire             = (state == DISPATCH) && found;
  assign last_cta         = (cta_x == grid_x - 32'd1) && (cta_y == grid_y - 32'd1) &&
                            (cta_z == grid_z - 32'd1);
  assign outstanding_next = outstanding + 32'(fire) - done_cnt;
  assign underflow        = (state != IDLE) &&
                            (({1'b0, outstanding} + 33'(fire)) < {1'b0, done_cnt});

  always_comb begin
    sel_onehot = '0;
    if (fire) sel_onehot[grant_idx] = 1'b1;
  end

  assign bus.launch_ready    = (state == IDLE);
  assign bus.busy            = (state != IDLE);
  assign bus.kernel_done     = (state == DONE);
  assign bus.dispatch_valid  = fire;
  assign bus.dispatch_sel    = sel_onehot;
  assign bus.dispatch_pc     = pc;
  assign bus.dispatch_param  = param;
  assign bus.dispatch_cta_x  = cta_x;
  assign bus.dispatch_cta_y  = cta_y;
  assign bus.dispatch_cta_z  = cta_z;
  assign bus.dispatch_cta_id = cta_id;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      param       <= '0;
      grid_x      <= '0;
      grid_y      <= '0;
      grid_z      <= '0;
      cta_x       <= '0;
      cta_y       <= '0;
      cta_z       <= '0;
      cta_id      <= '0;
      outstanding <= '0;
      last_grant  <= LAST_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (bus.launch_valid) begin
            pc          <= bus.launch_pc;
            param       <= bus.launch_param;
            grid_x      <= bus.launch_grid_x;
            grid_y      <= bus.launch_grid_y;
            grid_z      <= bus.launch_grid_z;
            cta_x       <= '0;
            cta_y       <= '0;
            cta_z       <= '0;
            cta_id      <= '0;
            outstanding <= '0;
            if ((bus.launch_grid_x == 32'd0) || (bus.launch_grid_y == 32'd0) ||
                (bus.launch_grid_z == 32'd0))
              state <= DONE;
            else
              state <= DISPATCH;
          end
        end
        DISPATCH: begin
          outstanding <= outstanding_next;
          if (fire) begin
            if (cta_x == grid_x - 32'd1) begin
              cta_x <= '0;
              if (cta_y == grid_y - 32'd1) begin
                cta_y <= '0;
                cta_z <= cta_z + 32'd1;
              end else begin
                cta_y <= cta_y + 32'd1;
              end
            end else begin
              cta_x <= cta_x + 32'd1;
            end
            cta_id     <= cta_id + 32'd1;
            last_grant <= grant_idx;
            if (last_cta) state <= DRAIN;
          end
        end
        DRAIN: begin
          outstanding <= outstanding_next;
          if (outstanding == 32'd0) state <= DONE;
        end
        DONE: begin
          outstanding <= outstanding_next;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Retiring more CTAs than were issued, or retiring while idle, is a core bug.
  assert property (@(posedge clk) disable iff (!reset) !underflow);
  assert property (@(posedge clk) disable iff (!reset) !((state == IDLE) && (|bus.cta_done)));
endmodule

// File: tb/tb_vx_kmu_cta_scheduler.sv
// Self-checking bench for vx_kmu_cta_scheduler: a per-cycle vector table for the
// basic kernel, plus a dispatch scoreboard and hand sequences for corner cases.
module tb_vx_kmu_cta_scheduler;
  localparam int NT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  vx_kmu_cta_scheduler_if #(.NUM_TARGETS(NT), .XLEN(32)) bus ();

  vx_kmu_cta_scheduler #(.NUM_TARGETS(NT), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] id;
    logic [31:0] pc;
    logic [31:0] param;
  } disp_t;

  typedef struct packed {
    logic [3:0] ready;
    logic [3:0] done;
    logic       valid;
    logic [3:0] sel;
    logic       kd;
    logic       busy;
    logic       lr;
  } cyc_t;

  disp_t exp_q[$];
  disp_t mon_act;
  disp_t mon_exp;
  cyc_t  tbl[9];

  int n_checks = 0;
  int n_pass   = 0;
  int kd_count = 0;
  int kd_before;

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("[TB] FAIL %s: event did not occur as required", name);
  endtask

  function automatic void push_exp(input logic [3:0] sel, input int x, input int y, input int z,
                                   input int id, input logic [31:0] pc, input logic [31:0] param);
    disp_t d;
    d.sel   = sel;
    d.x     = 32'(x);
    d.y     = 32'(y);
    d.z     = 32'(z);
    d.id    = 32'(id);
    d.pc    = pc;
    d.param = param;
    exp_q.push_back(d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds a descriptor until the scheduler takes it; returns in the first cycle after the handshake.
  task automatic apply_stimulus(input int gx, input int gy, input int gz,
                                input logic [31:0] pc, input logic [31:0] param);
    bit ok = 1'b0;
    bus.launch_grid_x = 32'(gx);
    bus.launch_grid_y = 32'(gy);
    bus.launch_grid_z = 32'(gz);
    bus.launch_pc     = pc;
    bus.launch_param  = param;
    bus.launch_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.launch_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    bus.launch_valid = 1'b0;
    if (!ok) fail_now("launch_accept");
  endtask

  task automatic wait_kd(input string name, input int expected);
    int n = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.kernel_done === 1'b1) begin
        n = i;
        break;
      end
      step();
    end
    step();
    check_output(name, n, expected);
  endtask

  // Scoreboard: every dispatch must match the oldest expected CTA record.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.kernel_done === 1'b1) kd_count++;
      if (bus.dispatch_valid === 1'b1) begin
        mon_act = {bus.dispatch_sel, bus.dispatch_cta_x, bus.dispatch_cta_y, bus.dispatch_cta_z,
                   bus.dispatch_cta_id, bus.dispatch_pc, bus.dispatch_param};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL unexpected_dispatch: got %0h expected no dispatch", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          check_output($sformatf("dispatch_id%0d", mon_exp.id), mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0] = {4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[1] = {4'b0011, 4'b0001, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0};
    tbl[2] = {4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[3] = {4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0};
    tbl[4] = {4'b0011, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = {4'b0011, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[6] = {4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[7] = {4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[8] = {4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};

    bus.launch_valid  = 1'b0;
    bus.launch_pc     = '0;
    bus.launch_param  = '0;
    bus.launch_grid_x = '0;
    bus.launch_grid_y = '0;
    bus.launch_grid_z = '0;
    bus.target_ready  = '0;
    bus.cta_done      = '0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.target_ready = 4'b1111;
    @(negedge clk);
    check_output("rst_ctrl", {bus.launch_ready, bus.busy, bus.dispatch_valid, bus.kernel_done,
                              bus.dispatch_sel}, {4'b1000, 4'b0000});
    check_output("rst_coords", {bus.dispatch_cta_x, bus.dispatch_cta_y, bus.dispatch_cta_z,
                                bus.dispatch_cta_id}, '0);
    check_output("rst_pc_param", {bus.dispatch_pc, bus.dispatch_param}, '0);
    step();

    // 2x2x1 grid on targets 0/1 only, per-cycle control table.
    $display("[TB] grid 2x2x1, two ready targets");
    bus.target_ready = 4'b0011;
    push_exp(4'b0001, 0, 0, 0, 0, 32'h1000, 32'hA000);
    push_exp(4'b0010, 1, 0, 0, 1, 32'h1000, 32'hA000);
    push_exp(4'b0001, 0, 1, 0, 2, 32'h1000, 32'hA000);
    push_exp(4'b0010, 1, 1, 0, 3, 32'h1000, 32'hA000);
    kd_before = kd_count;
    apply_stimulus(2, 2, 1, 32'h1000, 32'hA000);
    for (int i = 0; i < 9; i++) begin
      bus.target_ready = tbl[i].ready;
      bus.cta_done     = tbl[i].done;
      @(negedge clk);
      check_output($sformatf("t1_cyc%0d", i + 1),
                   {bus.dispatch_valid, bus.dispatch_sel, bus.kernel_done, bus.busy, bus.launch_ready},
                   {tbl[i].valid, tbl[i].sel, tbl[i].kd, tbl[i].busy, tbl[i].lr});
      step();
    end
    bus.cta_done = '0;
    check_output("t1_kd_once", kd_count - kd_before, 1);
    check_output("t1_q_empty", exp_q.size(), 0);

    // Zero-size grid goes straight to DONE.
    $display("[TB] grid 0x5x1");
    bus.target_ready = 4'b1111;
    apply_stimulus(0, 5, 1, 32'h1111, 32'h2222);
    @(negedge clk);
    check_output("t2_done_cycle", {bus.kernel_done, bus.busy, bus.launch_ready, bus.dispatch_valid},
                 4'b1100);
    step();
    @(negedge clk);
    check_output("t2_idle_cycle", {bus.kernel_done, bus.busy, bus.launch_ready, bus.dispatch_valid},
                 4'b0010);
    step();

    // Round-robin skipping and stall, from a fresh reset.
    $display("[TB] round-robin skip and stall");
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.target_ready = 4'b0101;
    push_exp(4'b0001, 0, 0, 0, 0, 32'h2000, 32'hB000);
    push_exp(4'b0100, 1, 0, 0, 1, 32'h2000, 32'hB000);
    push_exp(4'b0001, 2, 0, 0, 2, 32'h2000, 32'hB000);
    push_exp(4'b1000, 3, 0, 0, 3, 32'h2000, 32'hB000);
    push_exp(4'b0001, 4, 0, 0, 4, 32'h2000, 32'hB000);
    apply_stimulus(5, 1, 1, 32'h2000, 32'hB000);
    repeat (3) begin
      @(negedge clk);
      step();
    end
    bus.target_ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("t3_stall%0d_valid", i), bus.dispatch_valid, 1'b0);
      check_output($sformatf("t3_stall%0d_hold", i), {bus.dispatch_cta_x, bus.dispatch_cta_id,
                                                      bus.busy}, {32'd3, 32'd3, 1'b1});
      step();
    end
    bus.target_ready = 4'b1000;
    @(negedge clk);
    step();
    bus.target_ready = 4'b1111;
    @(negedge clk);
    step();
    bus.cta_done = 4'b1111;
    step();
    bus.cta_done = 4'b0001;
    step();
    bus.cta_done = 4'b0000;
    wait_kd("t3_kd_latency", 1);
    check_output("t3_q_empty", exp_q.size(), 0);

    // 3x1x2 grid wrapping into z, with a retire in the same cycle as dispatch #4.
    $display("[TB] grid 3x1x2 with concurrent retire");
    kd_before = kd_count;
    push_exp(4'b0010, 0, 0, 0, 0, 32'h3000, 32'hC000);
    push_exp(4'b0100, 1, 0, 0, 1, 32'h3000, 32'hC000);
    push_exp(4'b1000, 2, 0, 0, 2, 32'h3000, 32'hC000);
    push_exp(4'b0001, 0, 0, 1, 3, 32'h3000, 32'hC000);
    push_exp(4'b0010, 1, 0, 1, 4, 32'h3000, 32'hC000);
    push_exp(4'b0100, 2, 0, 1, 5, 32'h3000, 32'hC000);
    apply_stimulus(3, 1, 2, 32'h3000, 32'hC000);
    for (int i = 0; i < 6; i++) begin
      bus.cta_done = (i == 3) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      step();
    end
    bus.cta_done = 4'b1110;
    step();
    bus.cta_done = 4'b0011;
    step();
    bus.cta_done = 4'b0000;
    wait_kd("t4_kd_latency", 1);
    @(negedge clk);
    check_output("t4_idle_after", {bus.busy, bus.launch_ready}, 2'b01);
    step();
    check_output("t4_kd_once", kd_count - kd_before, 1);
    check_output("t4_q_empty", exp_q.size(), 0);

    // Reset part-way through an 8-CTA kernel, then a fresh 1x1x1 kernel.
    $display("[TB] reset mid-dispatch");
    push_exp(4'b1000, 0, 0, 0, 0, 32'h4000, 32'hD000);
    push_exp(4'b0001, 1, 0, 0, 1, 32'h4000, 32'hD000);
    apply_stimulus(8, 1, 1, 32'h4000, 32'hD000);
    repeat (2) begin
      @(negedge clk);
      step();
    end
    reset = 1'b0;
    bus.target_ready = 4'b0000;
    @(negedge clk);
    step();
    reset = 1'b1;
    bus.target_ready = 4'b1111;
    kd_before = kd_count;
    @(negedge clk);
    check_output("t5_after_reset", {bus.busy, bus.launch_ready, bus.dispatch_valid, bus.kernel_done},
                 4'b0100);
    check_output("t5_coords_cleared", {bus.dispatch_cta_x, bus.dispatch_cta_id}, '0);
    step();
    repeat (3) begin
      @(negedge clk);
      step();
    end
    check_output("t5_no_kd", kd_count - kd_before, 0);
    check_output("t5_q_empty_a", exp_q.size(), 0);
    push_exp(4'b0001, 0, 0, 0, 0, 32'h5000, 32'hE000);
    apply_stimulus(1, 1, 1, 32'h5000, 32'hE000);
    @(negedge clk);
    step();
    bus.cta_done = 4'b0001;
    step();
    bus.cta_done = 4'b0000;
    wait_kd("t5_kd_latency", 1);
    check_output("t5_q_empty_b", exp_q.size(), 0);

    // Second launch held valid through the first kernel.
    $display("[TB] back-to-back launches");
    kd_before = kd_count;
    push_exp(4'b0010, 0, 0, 0, 0, 32'h6000, 32'hF000);
    push_exp(4'b0100, 1, 0, 0, 1, 32'h6000, 32'hF000);
    push_exp(4'b1000, 0, 0, 0, 0, 32'h7000, 32'h7777);
    push_exp(4'b0001, 0, 1, 0, 1, 32'h7000, 32'h7777);
    bus.launch_grid_x = 32'd2;
    bus.launch_grid_y = 32'd1;
    bus.launch_grid_z = 32'd1;
    bus.launch_pc     = 32'h6000;
    bus.launch_param  = 32'hF000;
    bus.launch_valid  = 1'b1;
    step();
    bus.launch_grid_x = 32'd1;
    bus.launch_grid_y = 32'd2;
    bus.launch_pc     = 32'h7000;
    bus.launch_param  = 32'h7777;
    repeat (2) begin
      @(negedge clk);
      step();
    end
    bus.cta_done = 4'b0110;
    @(negedge clk);
    check_output("t6_held_not_accepted", {bus.launch_ready, bus.busy}, 2'b01);
    step();
    bus.cta_done = 4'b0000;
    wait_kd("t6_kd_first", 1);
    @(negedge clk);
    check_output("t6_ready_again", {bus.launch_ready, bus.busy}, 2'b10);
    step();
    bus.launch_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      step();
    end
    bus.cta_done = 4'b1001;
    step();
    bus.cta_done = 4'b0000;
    wait_kd("t6_kd_second", 1);
    check_output("t6_kd_twice", kd_count - kd_before, 2);
    check_output("t6_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vx_kmu_cta_scheduler.md
# vx_kmu_cta_scheduler

Sequences one kernel launch from the command processor into per-CTA dispatches. It walks the 3-D grid in x-fastest order and hands each CTA to one of `NUM_TARGETS` cores, using round-robin among cores that report a free slot. It tracks outstanding CTAs and signals kernel completion. It sits inside the KMU, between the command-processor kernel descriptor and the per-core task interfaces.

## Interface
- `NUM_TARGETS`, default 4: number of cores served; must be ≥ 1.
- `XLEN`, default 32: width of the PC and param fields.
- `clk  in  1`: clock.
- `reset  in  1`: reset, synchronous and active-low; one clock.
- `launch_valid  in  1`: kernel descriptor valid.
- `launch_ready  out  1`: scheduler can accept a launch.
- `launch_pc  in  XLEN`: kernel entry PC.
- `launch_param  in  XLEN`: kernel argument pointer.
- `launch_grid_x/y/z  in  32 each`: grid dimensions in CTAs.
- `target_ready  in  NUM_TARGETS`: core i has a free CTA slot this cycle.
- `dispatch_valid  out  1`: a CTA is issued this cycle.
- `dispatch_sel  out  NUM_TARGETS`: one-hot, the receiving core.
- `dispatch_pc`, `dispatch_param  out  XLEN`: latched launch fields.
- `dispatch_cta_x/y/z  out  32 each`: CTA coordinates.
- `dispatch_cta_id  out  32`: linear CTA index, modulo 2^32.
- `cta_done  in  NUM_TARGETS`: one-cycle pulse per CTA retired by core i.
- `kernel_done  out  1`: one-cycle completion pulse.
- `busy  out  1`: high whenever state ≠ IDLE.

## Operation
- **States**
  - IDLE: `launch_ready` = 1. On `launch_valid & launch_ready`, latch pc, param and grid, and clear the coordinates, id and outstanding count. If any grid dimension is 0, go to DONE; otherwise go to DISPATCH.
  - DISPATCH: `dispatch_valid` = `|target_ready`, combinational from registered state.
    - `dispatch_sel` is the first ready target searching upward, with wrap, from `(last_grant+1) mod NUM_TARGETS`.
    - A dispatch always transfers in the cycle it is asserted; no further handshake.
    - On each dispatch: x++. If x wraps at grid_x, x = 0 and y++. If y wraps at grid_y, y = 0 and z++. id++. `last_grant` ← selected target.
    - The dispatch of CTA (grid_x-1, grid_y-1, grid_z-1) moves the state to DRAIN.
  - DRAIN: go to DONE when the registered outstanding count is 0.
  - DONE: `kernel_done` = 1 for one cycle, then go to IDLE.
- **Outstanding count** (32 bits): next = cur + `dispatch_valid` − popcount(`cta_done`). Dispatch and done in the same cycle both apply. Underflow is a design error and is flagged with a simulation assertion. A `cta_done` in IDLE is ignored and asserted against.
- `dispatch_*` data outputs show the current registered coordinates at all times. They are meaningful only while `dispatch_valid` is high.
- **Reset values (`reset` low at a clock edge):**
  - state = IDLE; `last_grant` = NUM_TARGETS-1, so target 0 is served first.
  - Coordinates, id, outstanding, pc, param and grid all 0.
  - Output values: `launch_ready` = 1, `busy` = 0, `dispatch_valid` = 0, `dispatch_sel` = 0, `kernel_done` = 0.
  - Reset mid-launch abandons the kernel with no `kernel_done`.

## Timing
- A launch handshake at cycle t gives state DISPATCH at t+1. The first dispatch can occur at t+1.
- Throughput is at most one CTA per cycle. With N CTAs and at least one target always ready, dispatches fill cycles t+1..t+N and DRAIN starts at t+N+1.
- DRAIN→DONE takes one cycle after the outstanding count registers 0. `kernel_done` is high in the DONE cycle. `launch_ready` returns the cycle after.
- Zero-size grid: DONE at t+1, `kernel_done` at t+1, `launch_ready` at t+2.
- `launch_ready` is low from t+1 until IDLE; a `launch_valid` held during that time is not accepted.
- `target_ready` all low in DISPATCH: stall with `dispatch_valid` = 0 and no state change.

## Test plan
- **Grid 2×2×1, NUM_TARGETS = 2, all ready:** dispatches at t+1..t+4 with sel 01, 10, 01, 10, coords (0,0,0), (1,0,0), (0,1,0), (1,1,0) and id 0..3. Pulse `cta_done` four times → `kernel_done` exactly once, `busy` drops after it.
- **Grid 0×5×1:** no dispatch. `kernel_done` at t+1, `launch_ready` high at t+2.
- **Round-robin skip, NUM_TARGETS = 4:** `target_ready` = 0101 for three dispatches → sel 0001, 0100, 0001. Drop `target_ready` to 0000 for 3 cycles → no dispatch and coordinates hold.
- **Wrap across z, grid 3×1×2:** ids 0..5 with z going 0,0,0,1,1,1. Raise `cta_done` on the same cycle as dispatch #4 → outstanding stays consistent, final count 0, one `kernel_done`.
- **Reset mid-DISPATCH after 2 of 8 CTAs:** next cycle `busy` = 0, `launch_ready` = 1, no `kernel_done`. A new 1×1×1 launch dispatches to target 0 at (0,0,0).
- **Back-to-back launches:** the second `launch_valid` is held high through the first kernel. It is accepted the cycle after `kernel_done` and its dispatches use the new pc and param.
